// File: rtl/tuner_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tuner_sweep_ctrl
//
// Sweeps the microring heater DAC code from a programmed start code to an end
// code (inclusive) in steps of a programmed stride. It runs one power-detect
// transaction per code point and tracks the code with the highest detected
// power. At the end of the sweep it parks the DAC at that code.
//
// The block sits between the tuner top-level FSM and the power-detect PHY. It
// is the PHY's consumer: it issues read requests and accepts detect results.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_sweep_start       start pulse (honoured only in IDLE/DONE, abort low)
//   i_sweep_abort       abort level, sampled every cycle
//   i_code_start/end    sweep range, latched on start (end is inclusive)
//   i_code_stride       step, latched on start (0 behaves as 1)
//   o_dac_code          heater DAC code (registered)
//   o_pwr_read_val      read request to detector     (i_pwr_read_rdy back)
//   i_pwr_detect_val    detect result valid          (o_pwr_detect_rdy back)
//   i_pwr_detect_data   detect result word
//   o_sweep_busy        high in all states except IDLE/DONE
//   o_sweep_done        one-cycle pulse on normal completion
//   o_result_val        peak outputs valid until next accepted start or reset
//   o_peak_pwr/code     best power seen and the code it was seen at
// -----------------------------------------------------------------------------
module tuner_sweep_ctrl #(
  parameter int unsigned ADC_WIDTH = 8,
  parameter int unsigned DAC_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sweep_start,
  input  logic                 i_sweep_abort,
  input  logic [DAC_WIDTH-1:0] i_code_start,
  input  logic [DAC_WIDTH-1:0] i_code_end,
  input  logic [DAC_WIDTH-1:0] i_code_stride,
  output logic [DAC_WIDTH-1:0] o_dac_code,
  output logic                 o_pwr_read_val,
  input  logic                 i_pwr_read_rdy,
  input  logic                 i_pwr_detect_val,
  output logic                 o_pwr_detect_rdy,
  input  logic [ADC_WIDTH-1:0] i_pwr_detect_data,
  output logic                 o_sweep_busy,
  output logic                 o_sweep_done,
  output logic                 o_result_val,
  output logic [ADC_WIDTH-1:0] o_peak_pwr,
  output logic [DAC_WIDTH-1:0] o_peak_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SET    = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DETECT = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           state_q,      state_d;
  logic [DAC_WIDTH-1:0] end_q,        end_d;
  logic [DAC_WIDTH-1:0] stride_q,     stride_d;
  logic [DAC_WIDTH-1:0] cur_q,        cur_d;
  logic [DAC_WIDTH-1:0] dac_q,        dac_d;
  logic [ADC_WIDTH-1:0] peak_pwr_q,   peak_pwr_d;
  logic [DAC_WIDTH-1:0] peak_code_q,  peak_code_d;
  logic                 result_val_q, result_val_d;
  logic                 done_q,       done_d;
  logic                 first_q,      first_d;
  logic                 abort_pend_q, abort_pend_d;

  logic                 read_fire;
  logic                 det_fire;
  logic                 start_ok;
  logic [DAC_WIDTH:0]   next_code;
  logic                 last_point;

  assign read_fire = (state_q == S_READ)   && i_pwr_read_rdy;
  assign det_fire  = (state_q == S_DETECT) && i_pwr_detect_val;
  assign start_ok  = i_sweep_start && !i_sweep_abort;

  // One extra bit so a stride that steps past the top of the DAC range is
  // seen as overflow rather than wrapping back to a low code.
  assign next_code  = {1'b0, cur_q} + {1'b0, stride_q};
  assign last_point = next_code[DAC_WIDTH] || (next_code > {1'b0, end_q});

  always_comb begin
    state_d      = state_q;
    end_d        = end_q;
    stride_d     = stride_q;
    cur_d        = cur_q;
    dac_d        = dac_q;
    peak_pwr_d   = peak_pwr_q;
    peak_code_d  = peak_code_q;
    result_val_d = result_val_q;
    done_d       = 1'b0;
    first_d      = first_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d      = S_SET;
          end_d        = i_code_end;
          stride_d     = (i_code_stride == '0) ? DAC_WIDTH'(1) : i_code_stride;
          cur_d        = i_code_start;
          peak_pwr_d   = '0;
          peak_code_d  = '0;
          result_val_d = 1'b0;
          first_d      = 1'b1;
          abort_pend_d = 1'b0;
        end
      end

      S_SET: begin
        if (i_sweep_abort) begin
          state_d = S_IDLE;
        end else begin
          dac_d   = cur_q;
          state_d = S_READ;
        end
      end

      S_READ: begin
        // Once the read has fired the detector owes us a result, so an abort
        // in the same cycle is deferred until that result is accepted.
        if (read_fire) begin
          state_d      = S_DETECT;
          abort_pend_d = i_sweep_abort;
        end else if (i_sweep_abort) begin
          state_d = S_IDLE;
        end
      end

      S_DETECT: begin
        if (det_fire) begin
          // Strict compare keeps the lowest code on ties.
          if (first_q || (i_pwr_detect_data > peak_pwr_q)) begin
            peak_pwr_d  = i_pwr_detect_data;
            peak_code_d = cur_q;
          end
          first_d = 1'b0;
          if (abort_pend_q || i_sweep_abort) begin
            state_d      = S_IDLE;
            abort_pend_d = 1'b0;
          end else begin
            state_d = S_UPDATE;
          end
        end else if (i_sweep_abort) begin
          abort_pend_d = 1'b1;
        end
      end

      S_UPDATE: begin
        if (i_sweep_abort) begin
          state_d = S_IDLE;
        end else if (last_point) begin
          state_d      = S_DONE;
          result_val_d = 1'b1;
          done_d       = 1'b1;
          dac_d        = peak_code_q;
        end else begin
          cur_d   = next_code[DAC_WIDTH-1:0];
          state_d = S_SET;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      end_q        <= '0;
      stride_q     <= '0;
      cur_q        <= '0;
      dac_q        <= '0;
      peak_pwr_q   <= '0;
      peak_code_q  <= '0;
      result_val_q <= 1'b0;
      done_q       <= 1'b0;
      first_q      <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      end_q        <= end_d;
      stride_q     <= stride_d;
      cur_q        <= cur_d;
      dac_q        <= dac_d;
      peak_pwr_q   <= peak_pwr_d;
      peak_code_q  <= peak_code_d;
      result_val_q <= result_val_d;
      done_q       <= done_d;
      first_q      <= first_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Handshake and busy outputs decode straight from the state register.
  assign o_pwr_read_val   = (state_q == S_READ);
  assign o_pwr_detect_rdy = (state_q == S_DETECT);
  assign o_sweep_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_sweep_done     = done_q;
  assign o_result_val     = result_val_q;
  assign o_dac_code       = dac_q;
  assign o_peak_pwr       = peak_pwr_q;
  assign o_peak_code      = peak_code_q;

endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
module tb_tuner_sweep_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_sweep_start = 1'b0, i_sweep_abort = 1'b0;
  logic [DW-1:0] i_code_start = '0, i_code_end = '0, i_code_stride = '0;
  logic [DW-1:0] o_dac_code;
  logic          o_pwr_read_val, o_pwr_detect_rdy;
  logic          i_pwr_read_rdy = 1'b0, i_pwr_detect_val = 1'b0;
  logic [AW-1:0] i_pwr_detect_data = '0;
  logic          o_sweep_busy, o_sweep_done, o_result_val;
  logic [AW-1:0] o_peak_pwr;
  logic [DW-1:0] o_peak_code;

  always #5 clk = ~clk;

  tuner_sweep_ctrl #(.ADC_WIDTH(AW), .DAC_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_sweep_start(i_sweep_start), .i_sweep_abort(i_sweep_abort),
    .i_code_start(i_code_start), .i_code_end(i_code_end), .i_code_stride(i_code_stride),
    .o_dac_code(o_dac_code),
    .o_pwr_read_val(o_pwr_read_val), .i_pwr_read_rdy(i_pwr_read_rdy),
    .i_pwr_detect_val(i_pwr_detect_val), .o_pwr_detect_rdy(o_pwr_detect_rdy),
    .i_pwr_detect_data(i_pwr_detect_data),
    .o_sweep_busy(o_sweep_busy), .o_sweep_done(o_sweep_done), .o_result_val(o_result_val),
    .o_peak_pwr(o_peak_pwr), .o_peak_code(o_peak_code)
  );

  typedef logic [0:7][7:0] bytes8_t;
  typedef struct {
    logic [7:0]  cs, ce, cst;
    int unsigned lat, hold, n;
    bytes8_t     data, codes;
    logic [7:0]  pk_pwr, pk_code;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int unsigned checks = 0, failures = 0;

  // detector model state
  int unsigned lat = 1, hold = 0, wait_left = 0, phy_cnt = 0, pt_idx = 0;
  int unsigned n_rd = 0, n_det = 0, n_done = 0, n_overlap = 0, n_unstable = 0;
  bit          phy_pend = 0, rd_seen = 0;
  bytes8_t     cur_data = '0;
  logic [7:0]  log_codes [16];
  logic        prev_rv = 1'b0;
  logic [7:0]  prev_dac = '0;

  function automatic vec_t mk(input logic [7:0] cs, ce, cst, input int unsigned l, h, n,
                              input bytes8_t d, c, input logic [7:0] pp, pc);
    vec_t v;
    v.cs = cs; v.ce = ce; v.cst = cst; v.lat = l; v.hold = h; v.n = n;
    v.data = d; v.codes = c; v.pk_pwr = pp; v.pk_code = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_rd = 0; n_det = 0; n_done = 0; n_overlap = 0; n_unstable = 0;
  endtask

  // One clock: observe handshakes before the edge, update the detector model after it.
  task automatic cycle();
    bit det_fired;
    det_fired = 0;
    if (o_pwr_read_val && o_pwr_detect_rdy) n_overlap++;
    if (o_pwr_read_val && prev_rv && (o_dac_code !== prev_dac)) n_unstable++;
    prev_rv = o_pwr_read_val;
    prev_dac = o_dac_code;
    if (o_sweep_done) n_done++;
    if (o_pwr_read_val && i_pwr_read_rdy) begin
      if (n_rd < 16) log_codes[n_rd] = o_dac_code;
      n_rd++;
      phy_pend = 1; phy_cnt = lat; rd_seen = 0;
    end
    if (o_pwr_detect_rdy && i_pwr_detect_val) begin
      n_det++; pt_idx++; det_fired = 1;
    end
    @(posedge clk); #1;
    i_sweep_start = 1'b0;
    i_sweep_abort = 1'b0;
    i_rst = 1'b0;
    if (det_fired) i_pwr_detect_val = 1'b0;
    if (phy_pend) begin
      if (phy_cnt > 1) phy_cnt--;
      else begin
        phy_pend = 0;
        i_pwr_detect_val = 1'b1;
        i_pwr_detect_data = (pt_idx < 8) ? cur_data[pt_idx] : 8'hEE;
      end
    end
    if (o_pwr_read_val) begin
      if (!rd_seen) begin rd_seen = 1; wait_left = hold; end
      i_pwr_read_rdy = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      i_pwr_read_rdy = 1'b0;
    end
  endtask

  task automatic setup_phy(input int unsigned l, input int unsigned h, input bytes8_t d);
    lat = l; hold = h; cur_data = d; pt_idx = 0; rd_seen = 0;
    phy_pend = 0; i_pwr_detect_val = 1'b0;
  endtask

  task automatic issue_start(input logic [7:0] cs, ce, cst);
    i_code_start = cs; i_code_end = ce; i_code_stride = cst;
    i_sweep_start = 1'b1;
    cycle();
  endtask

  task automatic run_vec(input int idx, input bit linger);
    vec_t v;
    int unsigned budget;
    v = vecs[idx];
    setup_phy(v.lat, v.hold, v.data);
    issue_start(v.cs, v.ce, v.cst);
    clear_counts();
    chk($sformatf("v%0d_busy_after_start", idx), o_sweep_busy, 1);
    chk($sformatf("v%0d_rv_clear", idx), o_result_val, 0);
    chk($sformatf("v%0d_read_not_yet", idx), o_pwr_read_val, 0);
    cycle();
    chk($sformatf("v%0d_read_val_n2", idx), o_pwr_read_val, 1);
    chk($sformatf("v%0d_dac_n2", idx), o_dac_code, v.cs);
    budget = 0;
    while (!o_sweep_done && budget < 2000) begin cycle(); budget++; end
    chk($sformatf("v%0d_timeout", idx), budget < 2000, 1);
    chk($sformatf("v%0d_read_fires", idx), n_rd, v.n);
    for (int k = 0; k < int'(v.n) && k < 8; k++)
      chk($sformatf("v%0d_code%0d", idx, k), log_codes[k], v.codes[k]);
    chk($sformatf("v%0d_peak_pwr", idx), o_peak_pwr, v.pk_pwr);
    chk($sformatf("v%0d_peak_code", idx), o_peak_code, v.pk_code);
    chk($sformatf("v%0d_dac_park", idx), o_dac_code, v.pk_code);
    chk($sformatf("v%0d_result_val", idx), o_result_val, 1);
    chk($sformatf("v%0d_busy_done", idx), o_sweep_busy, 0);
    if (!linger) begin
      repeat (3) cycle();
      chk($sformatf("v%0d_done_pulses", idx), n_done, 1);
      chk($sformatf("v%0d_overlap", idx), n_overlap, 0);
      chk($sformatf("v%0d_dac_unstable", idx), n_unstable, 0);
      chk($sformatf("v%0d_result_held", idx), o_result_val, 1);
      chk($sformatf("v%0d_dac_held", idx), o_dac_code, v.pk_code);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    vecs[0] = mk(10, 14, 1, 13, 0, 5, {8'd20, 8'd50, 8'd90, 8'd60, 8'd30, 8'd0, 8'd0, 8'd0},
                 {8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd0, 8'd0, 8'd0}, 90, 12);
    vecs[1] = mk(0, 10, 4, 2, 0, 3, {8'd5, 8'd7, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd0, 8'd4, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 7, 4);
    vecs[2] = mk(250, 255, 8, 2, 0, 1, {8'd77, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd250, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 77, 250);
    vecs[3] = mk(3, 6, 1, 3, 0, 4, {8'd40, 8'd40, 8'd40, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0}, 40, 3);
    vecs[4] = mk(9, 5, 1, 1, 0, 1, {8'd33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 33, 9);
    vecs[5] = mk(2, 5, 0, 2, 0, 4, {8'd1, 8'd9, 8'd9, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0}, 9, 3);
    vecs[6] = mk(0, 0, 1, 1, 0, 1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 0);
    vecs[7] = mk(254, 255, 1, 2, 0, 2, {8'd10, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd254, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 200, 255);
    vecs[8] = mk(60, 62, 1, 4, 7, 3, {8'd15, 8'd25, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd60, 8'd61, 8'd62, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 25, 61);
    vecs[9] = mk(1, 200, 255, 2, 0, 1, {8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 9, 1);

    // reset state
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac", o_dac_code, 0);
    chk("rst_busy", o_sweep_busy, 0);
    chk("rst_read_val", o_pwr_read_val, 0);
    chk("rst_detect_rdy", o_pwr_detect_rdy, 0);
    chk("rst_result_val", o_result_val, 0);
    cycle();

    for (int i = 0; i < NV; i++) run_vec(i, 0);

    // abort concurrent with start in DONE: ignored
    i_sweep_abort = 1'b1;
    issue_start(8'd1, 8'd3, 8'd1);
    chk("abort_start_ignored_busy", o_sweep_busy, 0);
    chk("abort_start_result_kept", o_result_val, 1);

    // abort in READ
    setup_phy(2, 100, {8'd11, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    issue_start(8'd20, 8'd25, 8'd1);
    clear_counts();
    cycle();
    chk("abr_read_val", o_pwr_read_val, 1);
    i_sweep_abort = 1'b1;
    cycle();
    chk("abr_busy", o_sweep_busy, 0);
    chk("abr_read_dropped", o_pwr_read_val, 0);
    repeat (3) cycle();
    chk("abr_done", n_done, 0);
    chk("abr_result_val", o_result_val, 0);
    chk("abr_dac", o_dac_code, 20);
    chk("abr_reads", n_rd, 0);

    // abort in DETECT, plus start while busy
    setup_phy(5, 3, {8'd55, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    issue_start(8'd30, 8'd35, 8'd1);
    clear_counts();
    cycle();
    i_code_start = 8'd100;
    i_sweep_start = 1'b1;
    cycle();
    chk("busy_start_busy", o_sweep_busy, 1);
    chk("busy_start_dac", o_dac_code, 30);
    b = 0;
    while (!o_pwr_detect_rdy && b < 100) begin cycle(); b++; end
    chk("abd_reach_detect", b < 100, 1);
    i_sweep_abort = 1'b1;
    cycle();
    chk("abd_still_detect", o_pwr_detect_rdy, 1);
    b = 0;
    while (o_sweep_busy && b < 100) begin cycle(); b++; end
    chk("abd_idle_timeout", b < 100, 1);
    chk("abd_det_accepted", n_det, 1);
    chk("abd_val_cleared", i_pwr_detect_val, 0);
    chk("abd_reads", n_rd, 1);
    repeat (3) cycle();
    chk("abd_done", n_done, 0);
    chk("abd_result_val", o_result_val, 0);
    chk("abd_stay_idle", o_sweep_busy, 0);
    chk("abd_dac", o_dac_code, 30);

    // reset mid-DETECT on the second point
    setup_phy(6, 0, {8'd70, 8'd80, 8'd90, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    issue_start(8'd40, 8'd42, 8'd1);
    clear_counts();
    b = 0;
    while (!(o_pwr_detect_rdy && n_det == 1) && b < 200) begin cycle(); b++; end
    chk("rmd_reach", b < 200, 1);
    chk("rmd_pre_peak", o_peak_pwr, 70);
    chk("rmd_pre_dac", o_dac_code, 41);
    i_rst = 1'b1;
    cycle();
    phy_pend = 0; i_pwr_detect_val = 1'b0;
    chk("rmd_dac", o_dac_code, 0);
    chk("rmd_read_val", o_pwr_read_val, 0);
    chk("rmd_detect_rdy", o_pwr_detect_rdy, 0);
    chk("rmd_busy", o_sweep_busy, 0);
    chk("rmd_done", o_sweep_done, 0);
    chk("rmd_result_val", o_result_val, 0);
    chk("rmd_peak_pwr", o_peak_pwr, 0);
    chk("rmd_peak_code", o_peak_code, 0);
    cycle();

    // clean sweep after reset, then a start in the DONE cycle
    run_vec(0, 1);
    run_vec(3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
